rv32i_alu_arbiter: RTL
======================

Name: rv32i_alu_arbiter

Overview:
Round-robin arbiter that shares the single rv32i_alu execute datapath between NUM_REQ requesters, for example the main decode path and a debug/CSR helper. Each requester presents a one-hot ALU op and two operands on a valid/ready handshake. The arbiter issues one op per cycle into the ALU and tracks issue order in a tag FIFO. It routes each ALU result back to the requester that issued it, and handles ALU stall and pipeline flush.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TAG_DEPTH, 2, in-flight ops tracked (power of 2, >=2)
ALU_W, `ALU_WIDTH (14), one-hot op width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_req_valid  in  NUM_REQ  per-requester op valid
o_req_ready  out  NUM_REQ  per-requester accept; at most one bit set
i_req_op  in  NUM_REQ*ALU_W  one-hot op per requester, packed, requester 0 in LSBs
i_req_a  in  NUM_REQ*32  operand A per requester
i_req_b  in  NUM_REQ*32  operand B per requester
i_flush  in  1  pipeline flush
o_alu_ce  out  1  issue strobe to ALU i_ce
o_alu_op  out  ALU_W  to ALU i_alu
o_alu_a  out  32  to ALU i_rs1
o_alu_b  out  32  to ALU i_imm/rs2 operand
i_alu_stall  in  1  ALU o_stall_from_alu | o_stall
i_alu_y  in  32  ALU o_y
i_alu_y_valid  in  1  ALU o_ce (result valid)
o_rsp_valid  out  NUM_REQ  one-hot result strobe, no backpressure
o_rsp_y  out  32  result data
o_err_orphan  out  1  sticky: result arrived with empty tag FIFO

Behaviour:
- Reset: all outputs 0. Round-robin pointer = 0, tag FIFO empty, state IDLE.
- can_issue = !i_alu_stall & !i_flush & state!=DRAIN & (count<TAG_DEPTH | pop this cycle).
- Grant: first valid requester scanning from the pointer upward, mod NUM_REQ. o_req_ready[g] = can_issue & i_req_valid[g]. Ready may depend on valid; it is combinational.
- Pointer update: on accept, pointer <= g+1 mod NUM_REQ. With no accept, the pointer holds.
- Issue is registered. On the cycle after accept: o_alu_ce=1, and o_alu_op/a/b carry the granted request. Otherwise o_alu_ce=0 and data holds. Push of tag g happens in the accept cycle.
- Response: on i_alu_y_valid with FIFO non-empty, pop the head tag t. In the same cycle o_rsp_valid = 1<<t and o_rsp_y = i_alu_y (combinational pass-through). Requester-to-result latency is 2 cycles with no stall.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo TAG_DEPTH.
- Full FIFO (count==TAG_DEPTH) without a pop: no ready asserted.
- Orphan: i_alu_y_valid with an empty FIFO is dropped, no response, and o_err_orphan <= 1 until reset.
- Stall: while i_alu_stall=1 there is no accept. Any op already registered stays on o_alu_* with o_alu_ce held.
- FSM:
  - IDLE: count==0. Moves to BUSY on push.
  - BUSY: count>0. Moves to IDLE when count reaches 0.
  - Any state on i_flush goes to DRAIN: FIFO cleared, o_alu_ce<=0, no accept.
  - DRAIN lasts exactly 1 cycle. i_alu_y_valid is ignored in DRAIN (no response, no orphan flag). Then IDLE.
- Flush and accept in the same cycle: flush wins.
- Reset mid-operation: everything returns to reset values immediately. In-flight results are lost.

Optional Feature:
Macro RV32I_ALU_ARB_ONEHOT_CHK_EN.
- Defined: a granted op that is not $onehot is accepted but not issued (o_alu_ce stays 0). It is not pushed to the ALU. The requester gets o_rsp_valid on the next cycle with o_rsp_y = 32'hDEADBEEF, and o_err_op (extra 1-bit port) pulses for 1 cycle. Normal responses arriving in the same cycle take priority, and the error response is delayed 1 cycle.
- Undefined: no check is made, the op is passed through unchanged, and the o_err_op port is absent.

Decomposition:
- Package rv32i_alu_arb_pkg holds:
  - state enum {IDLE, BUSY, DRAIN}
  - the ALU_W one-hot bit index constants ADD=0..GEU=13, shared with the bench reference model
  - the ERR_RESULT constant 32'hDEADBEEF
- The tag FIFO is a natural sub-module: rv32i_alu_tag_fifo, parameterised by depth and tag width $clog2(NUM_REQ), with push/pop/count/clear.

Test Plan:
- Single request: req0 ADD, a=12, b=10 → ready0 in cycle 0, o_alu_ce in cycle 1, ALU result 22 → o_rsp_valid=2'b01, o_rsp_y=22.
- Both requesters valid continuously: req0 XOR(12,10), req1 OR(12,10) → grants alternate 0,1,0,1. Responses are 6 to req0 and 14 to req1, in issue order.
- Hold i_alu_stall=1 for 3 cycles with FIFO holding 1 op → no ready, o_alu_* unchanged. After release the response arrives once and correctly tagged.
- Fill the FIFO (2 issued, no result returned) → ready=0. Then one i_alu_y_valid with a new request in the same cycle → pop and push together, count stays 2.
- i_flush with 2 in flight → DRAIN for 1 cycle, a result in that cycle is ignored, then IDLE with count 0 and o_err_orphan=0. A later spurious i_alu_y_valid sets o_err_orphan=1.
- With the macro defined: op=14'b11 → no o_alu_ce, and the next cycle has o_rsp_y=32'hDEADBEEF with o_err_op=1.

Source files
------------

// File: rtl/rv32i_alu_arb_pkg.sv
// Shared types and constants for the rv32i ALU arbiter slice.
// Provides the default one-hot op width through the ALU_WIDTH macro when no
// other file has defined it.
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif

package rv32i_alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Bit positions inside the one-hot ALU op vector
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_AND  = 6;
  localparam int unsigned ALU_SLL  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SRA  = 9;
  localparam int unsigned ALU_EQ   = 10;
  localparam int unsigned ALU_NEQ  = 11;
  localparam int unsigned ALU_GE   = 12;
  localparam int unsigned ALU_GEU  = 13;

  localparam logic [31:0] ERR_RESULT = 32'hDEADBEEF;

endpackage

// File: rtl/rv32i_alu_tag_fifo.sv
// Tag FIFO recording which requester issued each in-flight ALU op.
// Synchronous clear drops every entry; clear wins over push and pop.
module rv32i_alu_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [TAG_W-1:0]       i_push_tag,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [TAG_W-1:0]       o_head_tag,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next pointers and occupancy; pointers wrap naturally at a power-of-2 depth
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (i_push) wr_d = wr_q + PTR_W'(1);
      if (i_pop)  rd_d = rd_q + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count registers and tag storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (i_push && !i_clear) mem_q[wr_q] <= i_push_tag;
    end
  end

  assign o_head_tag = mem_q[rd_q];
  assign o_count    = cnt_q;

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Round-robin arbiter sharing one rv32i ALU between NUM_REQ requesters.
// Optional macro RV32I_ALU_ARB_ONEHOT_CHK_EN: rejects non-one-hot ops with an
// ERR_RESULT response and adds the o_err_op port.
module rv32i_alu_arbiter
  import rv32i_alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_DEPTH = 2,
  parameter int unsigned ALU_W     = `ALU_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] i_req_op,
  input  logic [NUM_REQ*32-1:0]  i_req_a,
  input  logic [NUM_REQ*32-1:0]  i_req_b,
  input  logic                   i_flush,
  output logic                   o_alu_ce,
  output logic [ALU_W-1:0]       o_alu_op,
  output logic [31:0]            o_alu_a,
  output logic [31:0]            o_alu_b,
  input  logic                   i_alu_stall,
  input  logic [31:0]            i_alu_y,
  input  logic                   i_alu_y_valid,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [31:0]            o_rsp_y,
  output logic                   o_err_orphan
`ifdef RV32I_ALU_ARB_ONEHOT_CHK_EN
  ,
  output logic                   o_err_op
`endif
);

  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  arb_state_t       state_q, state_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic             ce_q, ce_d;
  logic [ALU_W-1:0] op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             orphan_q, orphan_d;

  logic             gnt_any;
  logic [TAG_W-1:0] gnt;
  logic [ALU_W-1:0] op_sel;
  logic [31:0]      a_sel, b_sel;
  logic             can_issue, accept, push, pop, op_ok;
  logic [TAG_W-1:0] head_tag;
  logic [CNT_W-1:0] count, count_nxt;

  rv32i_alu_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (push),
    .i_push_tag (gnt),
    .i_pop      (pop),
    .i_clear    (i_flush),
    .o_head_tag (head_tag),
    .o_count    (count)
  );

  // Round-robin grant: two passes (from pointer upward, then wrap) avoid a modulo
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_any && i_req_valid[j] && (TAG_W'(j) >= rr_q)) begin
        gnt_any = 1'b1;
        gnt     = TAG_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_any && i_req_valid[j] && (TAG_W'(j) < rr_q)) begin
        gnt_any = 1'b1;
        gnt     = TAG_W'(j);
      end
    end
  end

  // Select the granted requester's op and operands
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (TAG_W'(j) == gnt) begin
        op_sel = i_req_op[j*ALU_W +: ALU_W];
        a_sel  = i_req_a[j*32 +: 32];
        b_sel  = i_req_b[j*32 +: 32];
      end
    end
  end

`ifdef RV32I_ALU_ARB_ONEHOT_CHK_EN
  logic             err_pend_q, err_pend_d;
  logic [TAG_W-1:0] err_tag_q, err_tag_d;
  assign op_ok = $onehot(op_sel);
`else
  assign op_ok = 1'b1;
`endif

  assign pop = i_alu_y_valid && (count != '0) && (state_q != DRAIN);

  // A pending error response blocks new accepts so only one can be outstanding
  always_comb begin
    can_issue = !i_alu_stall && !i_flush && (state_q != DRAIN) &&
                ((count < CNT_W'(TAG_DEPTH)) || pop);
`ifdef RV32I_ALU_ARB_ONEHOT_CHK_EN
    can_issue = can_issue && !err_pend_q;
`endif
  end

  assign accept = can_issue && gnt_any;
  assign push   = accept && op_ok;

  // Ready is the single granted bit; pointer moves past the accepted requester
  always_comb begin
    o_req_ready = '0;
    rr_d        = rr_q;
    if (accept) begin
      o_req_ready[gnt] = 1'b1;
      rr_d = (gnt == TAG_W'(NUM_REQ - 1)) ? '0 : gnt + TAG_W'(1);
    end
  end

  // Issue register: loads on push, holds during stall, drops on flush
  always_comb begin
    ce_d = ce_q;
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    if (i_flush) begin
      ce_d = 1'b0;
    end else if (push) begin
      ce_d = 1'b1;
      op_d = op_sel;
      a_d  = a_sel;
      b_d  = b_sel;
    end else if (!i_alu_stall) begin
      ce_d = 1'b0;
    end
  end

  // FSM next state: occupancy-tracking IDLE/BUSY plus a one-cycle DRAIN on flush
  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    state_d = state_q;
    if (i_flush) begin
      state_d = DRAIN;
    end else begin
      case (state_q)
        IDLE:    if (push) state_d = BUSY;
        BUSY:    if (count_nxt == '0) state_d = IDLE;
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky orphan flag: result with nothing in flight, outside DRAIN
  assign orphan_d = orphan_q ||
                    (i_alu_y_valid && (count == '0) && (state_q != DRAIN));

`ifdef RV32I_ALU_ARB_ONEHOT_CHK_EN
  // Error response waits out any cycle in which a real result is returned
  always_comb begin
    err_pend_d = err_pend_q;
    err_tag_d  = err_tag_q;
    if (i_flush) begin
      err_pend_d = 1'b0;
    end else if (accept && !op_ok) begin
      err_pend_d = 1'b1;
      err_tag_d  = gnt;
    end else if (err_pend_q && !pop) begin
      err_pend_d = 1'b0;
    end
  end

  // Error response state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_pend_q <= 1'b0;
      err_tag_q  <= '0;
    end else begin
      err_pend_q <= err_pend_d;
      err_tag_q  <= err_tag_d;
    end
  end

  assign o_err_op = err_pend_q && !pop;
`endif

  // Response routing: ALU result passes straight through to the head tag
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_y     = '0;
    if (pop) begin
      o_rsp_valid[head_tag] = 1'b1;
      o_rsp_y               = i_alu_y;
    end
`ifdef RV32I_ALU_ARB_ONEHOT_CHK_EN
    else if (err_pend_q) begin
      o_rsp_valid[err_tag_q] = 1'b1;
      o_rsp_y                = ERR_RESULT;
    end
`endif
  end

  // Arbiter state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      ce_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      ce_q     <= ce_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      orphan_q <= orphan_d;
    end
  end

  assign o_alu_ce     = ce_q;
  assign o_alu_op     = op_q;
  assign o_alu_a      = a_q;
  assign o_alu_b      = b_q;
  assign o_err_orphan = orphan_q;

endmodule
